// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared types and helpers for the tinyALU random-stimulus engine.
// Holds the ALU operation encoding, the generator state enum, the LFSR
// feedback polynomial and the mapping from random bits to an operation.
package tinyalu_pkg;

    // ALU operation codes as driven on the op pins.
    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    // Stimulus generator sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GEN   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_NOP   = 3'd3,
        ST_RST   = 3'd4,
        ST_FIN   = 3'd5
    } stim_state_t;

    // Right-shifting Galois LFSR taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One step of the Galois LFSR: shift right, fold the tap mask in when
    // the bit shifted out is set.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = {1'b0, cur[31:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // Map the three op-choice bits onto an operation. Two codes map to
    // no_op and two to rst_op, so the mix is 2/8 idle, 2/8 reset, 4/8 ALU.
    function automatic operation_t op_choice(input logic [2:0] bits);
        operation_t sel;
        case (bits)
            3'b000:  sel = no_op;
            3'b001:  sel = add_op;
            3'b010:  sel = and_op;
            3'b011:  sel = xor_op;
            3'b100:  sel = mul_op;
            3'b101:  sel = no_op;
            3'b110:  sel = rst_op;
            3'b111:  sel = rst_op;
            default: sel = no_op;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/tinyalu_stim_gen_lfsr32.sv
// lfsr32: 32-bit Galois LFSR used as the random source of the stimulus
// engine. 'load' reloads the seed (an all-zero seed would lock the register,
// so it is replaced by 1); 'step' advances one position. 'value_next' exposes
// the value the register takes on the next step so callers can register
// fields drawn from the new value in the same cycle the register advances.
module lfsr32
    import tinyalu_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2D5F
) (
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value,
    output logic [31:0] value_next
);

    localparam logic [31:0] SEED_SAFE = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

    // Next-state of the shift register, shared with the consumer.
    always_comb begin
        value_next = lfsr_step(value);
    end

    // Shift register: reload has priority over stepping.
    always_ff @(posedge clk) begin
        if (load) begin
            value <= SEED_SAFE;
        end else if (step) begin
            value <= value_next;
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/tinyalu_stim_gen.sv
// tinyalu_stim_gen: LFSR-driven random stimulus engine for the tinyALU.
// Issues a programmed number of random operations over the start/done
// handshake, captures results, inserts ALU reset pulses and aborts a run
// when the ALU fails to answer within TIMEOUT cycles.
// Optional build macro: TINYALU_STIM_CORNER_EN biases each operand towards
// all-zeros / all-ones using a 2-bit LFSR field (A: bits 20:19, B: 22:21).
module tinyalu_stim_gen #(
    parameter int          DATA_W  = 8,
    parameter int          COUNT_W = 16,
    parameter logic [31:0] SEED    = 32'hACE1_2D5F,
    parameter int          TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go_i,
    input  logic [COUNT_W-1:0]    num_ops_i,
    output logic [DATA_W-1:0]     A,
    output logic [DATA_W-1:0]     B,
    output logic [2:0]            op,
    output logic                  start,
    output logic                  alu_reset,
    input  logic                  done_i,
    input  logic [2*DATA_W-1:0]   result_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  result_vld_o,
    output logic [COUNT_W-1:0]    ops_done_o,
    output logic                  busy_o,
    output logic                  finished_o,
    output logic                  timeout_o
);

    import tinyalu_pkg::*;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_ONE  = WAIT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);
    localparam logic [COUNT_W:0]   EXT_ONE   = (COUNT_W + 1)'(1);

    stim_state_t          state_r;
    logic [COUNT_W-1:0]   num_ops_r;
    logic [WAIT_W-1:0]    wait_cnt_r;

    logic [31:0]          lfsr_value_s;
    logic [31:0]          lfsr_next_s;
    logic                 lfsr_step_s;

    operation_t           gen_choice_s;
    logic [DATA_W-1:0]    gen_a_s;
    logic [DATA_W-1:0]    gen_b_s;
    logic [COUNT_W:0]     ops_plus_one_s;
    logic                 more_ops_s;
    logic                 unused_lfsr_s;

    // Spread an 8-bit LFSR slice over DATA_W bits (repeat for wide
    // operands, truncate for narrow ones).
    function automatic logic [DATA_W-1:0] replicate_byte(input logic [7:0] slice);
        logic [DATA_W-1:0] res;
        res = '0;
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = slice[i % 8];
        end
        return res;
    endfunction

`ifdef TINYALU_STIM_CORNER_EN
    // Corner bias: 00 forces all-zeros, 11 forces all-ones, else keep random.
    function automatic logic [DATA_W-1:0] bias_operand(input logic [DATA_W-1:0] raw,
                                                       input logic [1:0]        sel);
        logic [DATA_W-1:0] res;
        case (sel)
            2'b00:   res = '0;
            2'b11:   res = '1;
            default: res = raw;
        endcase
        return res;
    endfunction
`endif

    // The LFSR only moves in GEN; reset reloads the seed, runs never do.
    assign lfsr_step_s = (state_r == ST_GEN);

    lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk        (clk),
        .load       (reset),
        .step       (lfsr_step_s),
        .value      (lfsr_value_s),
        .value_next (lfsr_next_s)
    );

    // Only the low LFSR bits feed the op/operand fields; fold the rest away.
    assign unused_lfsr_s = ^{lfsr_value_s, lfsr_next_s[31:19]};

    // Draw op and operands from the value the LFSR takes at the end of GEN.
    always_comb begin
        gen_choice_s = op_choice(lfsr_next_s[2:0]);
`ifdef TINYALU_STIM_CORNER_EN
        gen_a_s = bias_operand(replicate_byte(lfsr_next_s[10:3]), lfsr_next_s[20:19]);
        gen_b_s = bias_operand(replicate_byte(lfsr_next_s[18:11]), lfsr_next_s[22:21]);
`else
        gen_a_s = replicate_byte(lfsr_next_s[10:3]);
        gen_b_s = replicate_byte(lfsr_next_s[18:11]);
`endif
    end

    // Decide whether the op completing now is the last one of the run;
    // the extra bit keeps the +1 from wrapping at the counter maximum.
    always_comb begin
        ops_plus_one_s = {1'b0, ops_done_o} + EXT_ONE;
        more_ops_s     = (ops_plus_one_s < {1'b0, num_ops_r});
    end

    // Sequencer: state, counters and every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            num_ops_r    <= '0;
            wait_cnt_r   <= '0;
            A            <= '0;
            B            <= '0;
            op           <= no_op;
            start        <= 1'b0;
            alu_reset    <= 1'b0;
            result_o     <= '0;
            result_vld_o <= 1'b0;
            ops_done_o   <= '0;
            busy_o       <= 1'b0;
            finished_o   <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            result_vld_o <= 1'b0;
            finished_o   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (go_i) begin
                        num_ops_r  <= num_ops_i;
                        ops_done_o <= '0;
                        timeout_o  <= 1'b0;
                        busy_o     <= 1'b1;
                        if (num_ops_i == {COUNT_W{1'b0}}) begin
                            state_r <= ST_FIN;
                        end else begin
                            state_r <= ST_GEN;
                        end
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                ST_GEN: begin
                    A          <= gen_a_s;
                    B          <= gen_b_s;
                    wait_cnt_r <= '0;
                    case (gen_choice_s)
                        no_op: begin
                            op      <= no_op;
                            start   <= 1'b1;
                            state_r <= ST_NOP;
                        end
                        rst_op: begin
                            op        <= rst_op;
                            start     <= 1'b0;
                            alu_reset <= 1'b1;
                            state_r   <= ST_RST;
                        end
                        default: begin
                            op      <= gen_choice_s;
                            start   <= 1'b1;
                            state_r <= ST_ISSUE;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    // done has priority over a timeout expiring this cycle.
                    if (done_i) begin
                        result_o     <= result_i;
                        result_vld_o <= 1'b1;
                        ops_done_o   <= ops_done_o + CNT_ONE;
                        start        <= 1'b0;
                        state_r      <= more_ops_s ? ST_GEN : ST_FIN;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        timeout_o <= 1'b1;
                        start     <= 1'b0;
                        state_r   <= ST_FIN;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_NOP: begin
                    start      <= 1'b0;
                    ops_done_o <= ops_done_o + CNT_ONE;
                    state_r    <= more_ops_s ? ST_GEN : ST_FIN;
                end
                ST_RST: begin
                    alu_reset  <= 1'b0;
                    ops_done_o <= ops_done_o + CNT_ONE;
                    state_r    <= more_ops_s ? ST_GEN : ST_FIN;
                end
                ST_FIN: begin
                    finished_o <= 1'b1;
                    busy_o     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    start     <= 1'b0;
                    alu_reset <= 1'b0;
                    busy_o    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_stim_gen.sv
// tb_tinyalu_stim_gen: randomized self-checking bench for tinyalu_stim_gen.
// A transaction-level model predicts the op/operand sequence from the LFSR
// polynomial and the op mix, and tracks run progress, results, timeouts and
// the finished/busy flags; one compare process checks every cycle.
module tb_tinyalu_stim_gen;

    localparam int          TIMEOUT = 64;
    localparam logic [31:0] SEED    = 32'hACE1_2D5F;
    localparam int K_NONE = 0, K_ISSUE = 1, K_NOP = 2, K_RST = 3;

    logic        clk = 1'b0;
    logic        reset, go_i, done_i;
    logic [15:0] num_ops_i, result_i;
    logic [7:0]  A, B;
    logic [2:0]  op;
    logic        start, alu_reset, result_vld_o, busy_o, finished_o, timeout_o;
    logic [15:0] result_o, ops_done_o;

    int n_checks = 0;
    int n_err    = 0;

    tinyalu_stim_gen #(.DATA_W(8), .COUNT_W(16), .SEED(SEED), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .go_i(go_i), .num_ops_i(num_ops_i),
        .A(A), .B(B), .op(op), .start(start), .alu_reset(alu_reset),
        .done_i(done_i), .result_i(result_i), .result_o(result_o),
        .result_vld_o(result_vld_o), .ops_done_o(ops_done_o), .busy_o(busy_o),
        .finished_o(finished_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] prbs_next(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    function automatic void draw(input logic [31:0] v, output int kind, output logic [2:0] eop,
                                 output logic [7:0] ea, output logic [7:0] eb);
        int sel;
        sel = int'(v & 32'd7);
        case (sel)
            0, 5:    begin kind = K_NOP;   eop = 3'd0; end
            6, 7:    begin kind = K_RST;   eop = 3'd7; end
            default: begin kind = K_ISSUE; eop = 3'(sel); end
        endcase
        ea = 8'((v >> 3) & 32'hFF);
        eb = 8'((v >> 11) & 32'hFF);
`ifdef TINYALU_STIM_CORNER_EN
        if (((v >> 19) & 32'd3) == 32'd0) ea = 8'h00;
        if (((v >> 19) & 32'd3) == 32'd3) ea = 8'hFF;
        if (((v >> 21) & 32'd3) == 32'd0) eb = 8'h00;
        if (((v >> 21) & 32'd3) == 32'd3) eb = 8'hFF;
`endif
    endfunction

    logic [31:0] m_lfsr;
    int          m_kind, m_wait, m_ops, m_num;
    logic        m_busy, m_to, m_fin_next;
    logic [15:0] m_res;
    logic        s_go, s_reset, s_done, p_start;
    logic [15:0] s_num, s_res;
    int          start_cycles = 0, stat_ops = 0, stat_a0 = 0, stat_aff = 0;
    logic        stats_on = 1'b0;

    task automatic model_cycle();
        logic idle_before, exp_fin, exp_vld, new_op;
        int kind;
        logic [2:0] eop;
        logic [7:0] ea, eb;
        if (start === 1'b1) start_cycles++;
        if (s_reset) begin
            m_lfsr = SEED; m_kind = K_NONE; m_wait = 0; m_ops = 0; m_num = 0;
            m_busy = 1'b0; m_to = 1'b0; m_fin_next = 1'b0; m_res = 16'h0;
            chk("rst_A", A, 8'h00);              chk("rst_B", B, 8'h00);
            chk("rst_op", op, 3'd0);             chk("rst_start", start, 1'b0);
            chk("rst_alu_reset", alu_reset, 1'b0); chk("rst_result", result_o, 16'h0);
            chk("rst_vld", result_vld_o, 1'b0);  chk("rst_ops", ops_done_o, 16'h0);
            chk("rst_busy", busy_o, 1'b0);       chk("rst_fin", finished_o, 1'b0);
            chk("rst_timeout", timeout_o, 1'b0);
        end else begin
            idle_before = !m_busy;
            exp_fin = m_fin_next; m_fin_next = 1'b0; exp_vld = 1'b0;
            if (exp_fin) m_busy = 1'b0;
            case (m_kind)
                K_ISSUE: begin
                    if (s_done) begin
                        exp_vld = 1'b1; m_res = s_res; m_ops++; m_kind = K_NONE;
                        if (m_ops == m_num) m_fin_next = 1'b1;
                        chk("issue_start_drop", start, 1'b0);
                    end else if (m_wait == TIMEOUT) begin
                        m_to = 1'b1; m_kind = K_NONE; m_fin_next = 1'b1;
                        chk("timeout_start_drop", start, 1'b0);
                    end else begin
                        m_wait++;
                        chk("issue_start_hold", start, 1'b1);
                    end
                end
                K_NOP: begin
                    m_ops++; m_kind = K_NONE;
                    if (m_ops == m_num) m_fin_next = 1'b1;
                    chk("nop_one_cycle", start, 1'b0);
                end
                K_RST: begin
                    m_ops++; m_kind = K_NONE;
                    if (m_ops == m_num) m_fin_next = 1'b1;
                    chk("rst_one_cycle", alu_reset, 1'b0);
                end
                default: ;
            endcase
            if (idle_before && s_go) begin
                m_busy = 1'b1; m_ops = 0; m_to = 1'b0; m_num = int'(s_num);
                if (s_num == 16'd0) m_fin_next = 1'b1;
            end
            new_op = (start === 1'b1 && p_start !== 1'b1) || (alu_reset === 1'b1);
            if (new_op) begin
                chk("op_allowed", (m_busy && m_kind == K_NONE && m_ops < m_num), 1'b1);
                m_lfsr = prbs_next(m_lfsr);
                draw(m_lfsr, kind, eop, ea, eb);
                chk("gen_A", A, ea); chk("gen_B", B, eb); chk("gen_op", op, eop);
                chk("gen_alu_reset", alu_reset, (kind == K_RST));
                chk("gen_start", start, (kind != K_RST));
                m_kind = kind; m_wait = 1;
                if (stats_on) begin
                    stat_ops++;
                    if (A == 8'h00) stat_a0++;
                    if (A == 8'hFF) stat_aff++;
                end
            end
            chk("finished", finished_o, exp_fin);
            chk("busy", busy_o, m_busy);
            chk("timeout", timeout_o, m_to);
            chk("ops_done", ops_done_o, 16'(m_ops));
            chk("result_vld", result_vld_o, exp_vld);
            chk("result", result_o, m_res);
            if (!m_busy) begin
                chk("idle_start", start, 1'b0);
                chk("idle_alu_reset", alu_reset, 1'b0);
            end
        end
    endtask

    // Compare process: sample what the DUT sees at the edge, check just after.
    initial begin
        forever begin
            @(posedge clk);
            s_go = go_i; s_num = num_ops_i; s_done = done_i; s_res = result_i;
            s_reset = reset; p_start = start;
            #1;
            model_cycle();
        end
    end

    // ---------------- ALU responder ----------------
    int resp_mode = 0;   // 0 silent, 1 fixed 3-cycle 1234, 2 random, 3 answer at TIMEOUT
    int resp_cnt = 0, resp_delay = 3;
    initial begin
        done_i = 1'b0; result_i = 16'h0;
        forever begin
            @(negedge clk);
            if (start === 1'b1 && resp_mode != 0) begin
                done_i = (resp_cnt == resp_delay - 1);
                result_i = (resp_mode == 1) ? 16'h1234 : 16'($urandom);
                resp_cnt++;
            end else begin
                resp_cnt = 0;
                resp_delay = (resp_mode == 2) ? int'($urandom_range(1, 4)) :
                             (resp_mode == 3) ? TIMEOUT : 3;
                done_i = (resp_mode == 2) && ($urandom_range(0, 7) == 0);
                result_i = 16'($urandom);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_run(input int n);
        @(negedge clk); go_i = 1'b1; num_ops_i = 16'(n);
        @(negedge clk); go_i = 1'b0;
    endtask

    task automatic wait_finish(input string nm, input int budget, output int cyc);
        cyc = 1;
        while (finished_o !== 1'b1 && cyc < budget) begin
            @(negedge clk); cyc++;
        end
        if (finished_o !== 1'b1) begin
            n_checks++; n_err++;
            $display("FAIL %s: finished_o not seen within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        int cyc;
        reset = 1'b1; go_i = 1'b0; num_ops_i = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // zero-op run: finished two cycles after go, nothing issued
        start_cycles = 0;
        start_run(0);
        wait_finish("zero_ops", 20, cyc);
        chk("zero_ops_latency", cyc, 2);
        chk("zero_ops_count", ops_done_o, 16'd0);
        chk("zero_ops_no_start", start_cycles, 0);

        // hung ALU: first op from the seed is mul D5*12
        resp_mode = 0; start_cycles = 0;
        start_run(3);
        @(negedge clk);
        chk("seed_A", A, 8'hD5); chk("seed_B", B, 8'h12); chk("seed_op", op, 3'd4);
        chk("seed_start", start, 1'b1);
        wait_finish("timeout_run", 200, cyc);
        chk("timeout_start_cycles", start_cycles, TIMEOUT);
        chk("timeout_flag", timeout_o, 1'b1);
        chk("timeout_ops", ops_done_o, 16'd0);

        // three ops, responder answers 1234 after 3 cycles
        resp_mode = 1;
        start_run(3);
        wait_finish("three_ops", 200, cyc);
        chk("three_ops_count", ops_done_o, 16'd3);
        chk("three_ops_no_timeout", timeout_o, 1'b0);

        // reset in the middle of a long run, then rerun from the seed
        resp_mode = 2;
        start_run(100);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_start", start, 1'b0);
        start_run(100);
        @(negedge clk);
        chk("rerun_A", A, 8'hD5); chk("rerun_B", B, 8'h12); chk("rerun_op", op, 3'd4);
        wait_finish("rerun", 3000, cyc);
        chk("rerun_count", ops_done_o, 16'd100);

        // done arriving on the very cycle the timeout expires
        resp_mode = 3;
        start_run(2);
        wait_finish("done_vs_timeout", 400, cyc);
        chk("done_wins_no_timeout", timeout_o, 1'b0);
        chk("done_wins_count", ops_done_o, 16'd2);

        // long random run with operand statistics
        resp_mode = 2; stat_ops = 0; stat_a0 = 0; stat_aff = 0; stats_on = 1'b1;
        start_run(1000);
        wait_finish("long_run", 20000, cyc);
        stats_on = 1'b0;
        chk("long_count", ops_done_o, 16'd1000);
        chk("long_ops_seen", stat_ops, 1000);
`ifdef TINYALU_STIM_CORNER_EN
        chk("corner_a_zero", (stat_a0 * 100 >= stat_ops * 20) && (stat_a0 * 100 <= stat_ops * 30), 1'b1);
        chk("corner_a_ones", (stat_aff * 100 >= stat_ops * 20) && (stat_aff * 100 <= stat_ops * 30), 1'b1);
`else
        chk("uniform_a_zero", (stat_a0 * 100 < stat_ops * 2), 1'b1);
        chk("uniform_a_ones", (stat_aff * 100 < stat_ops * 2), 1'b1);
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1);
    end

endmodule

// File: doc/tinyalu_stim_gen.md
# tinyalu_stim_gen

Synthesizable, parametrised random-stimulus engine for the tinyALU. It replaces the behavioural random-loop tester with an LFSR-driven generator that issues a programmed number of random operations over the ALU start/done handshake and captures results. It also inserts ALU reset operations and flags hung operations. It sits between the bench/top level (or an on-chip self-test controller) and the ALU operand/op/start/done pins.

## Interface
- `DATA_W`, 8: operand width; result is 2*DATA_W.
- `COUNT_W`, 16: width of operation counter.
- `SEED`, 32'hACE1_2D5F: LFSR initial value; 0 is replaced by 1.
- `TIMEOUT`, 64: max cycles to wait for `done_i` per operation.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `go_i`  in  1  start a run; sampled only in IDLE.
- `num_ops_i`  in  COUNT_W  operations to issue in this run; sampled with `go_i`.
- `A`  out  DATA_W  operand A to ALU.
- `B`  out  DATA_W  operand B to ALU.
- `op`  out  3  operation code (operation_t encoding).
- `start`  out  1  ALU start.
- `alu_reset`  out  1  one-cycle active-high reset pulse to ALU for rst_op.
- `done_i`  in  1  ALU done.
- `result_i`  in  2*DATA_W  ALU result.
- `result_o`  out  2*DATA_W  last captured result.
- `result_vld_o`  out  1  one-cycle pulse when `result_o` updates.
- `ops_done_o`  out  COUNT_W  operations completed this run.
- `busy_o`  out  1  high in any state but IDLE.
- `finished_o`  out  1  one-cycle pulse at end of run.
- `timeout_o`  out  1  sticky; set on a hung op, cleared by `reset` or next `go_i`.

## Operation
- States: IDLE, GEN, ISSUE, NOP, RST, FIN.
- IDLE: `go_i`=1 latches `num_ops_i` and clears `ops_done_o` and `timeout_o`. If `num_ops_i`==0, go to FIN. Otherwise go to GEN.
- GEN: 32-bit Galois LFSR (x^32+x^22+x^2+x+1) advances one step. The following are drawn from the new value:
  - op choice bits [2:0]: 000 no, 001 add, 010 and, 011 xor, 100 mul, 101 no, 110/111 rst.
  - A from bits [10:3]; B from bits [18:11]. For DATA_W>8, operands are replicated/truncated from the LFSR bits.
  - Outputs register at the end of GEN.
  - Next state: no_op→NOP; rst_op→RST; else→ISSUE.
- ISSUE: `start`=1 with A/B/op held stable. When `done_i`=1:
  - capture `result_i` into `result_o`; pulse `result_vld_o`;
  - increment `ops_done_o`; `start` drops the next cycle.
  - Next: GEN if `ops_done_o+1 < num_ops`, else FIN.
- ISSUE timeout: a wait counter reaching TIMEOUT sets `timeout_o`, drops `start`, and goes to FIN. The run is aborted and `ops_done_o` is not incremented.
- NOP: `start`=1 for exactly one cycle; no wait for `done_i`; no result capture. Increments `ops_done_o`.
- RST: `alu_reset`=1 for one cycle, `start`=0, `op`=rst_op. Increments `ops_done_o`.
- FIN: pulse `finished_o`; return to IDLE.
- LFSR is not reset between runs. Successive runs continue the sequence; only `reset` reloads SEED.

## Timing
- Reset values:
  - `A`, `B`, `result_o`, `ops_done_o` = 0.
  - `op` = no_op (000).
  - `start`, `alu_reset`, `result_vld_o`, `busy_o`, `finished_o`, `timeout_o` = 0.
  - State = IDLE; LFSR = SEED.
- `go_i` to first `start`: 2 cycles (IDLE→GEN→ISSUE).
- `start` is low for at least one cycle (GEN) between consecutive ops. ALU sees a fresh rising edge per op.
- `done_i` outside ISSUE is ignored.
- `done_i` and the timeout expiring in the same cycle: done wins.
- `reset` mid-run: every output returns to its reset value on the next edge; the run is dropped.
- `ops_done_o` at COUNT_W max: runs are limited to `num_ops_i` ≤ 2^COUNT_W−1, so no wrap.

## Configuration
- `TINYALU_STIM_CORNER_EN` defined: operand selection is biased. A 2-bit LFSR field per operand selects 00→all-zeros, 11→all-ones, otherwise random. This gives ~25% zero and ~25% ones per operand.
- Undefined: operands are the uniform LFSR slice. The op mix is unchanged.

## Structure
- In `tinyalu_pkg`: `operation_t` (no 000, add 001, and 010, xor 011, mul 100, rst 111), the state enum, the LFSR polynomial constant, and the op-choice mapping function.
- One sub-module: `lfsr32` (load, step, value). The FSM, counters and capture stay in `tinyalu_stim_gen`.

## Test plan
- `num_ops_i`=0, `go_i` pulse → `finished_o` pulse 2 cycles later, no `start`, `ops_done_o`=0.
- `num_ops_i`=3, responder asserts `done_i` 3 cycles after `start` (result 16'h1234) → non-NOP/RST ops show `result_vld_o` with 16'h1234; `ops_done_o`=3 at `finished_o`.
- Responder never asserts `done_i`, TIMEOUT=64, first op non-NOP → `start` high 64 cycles, `timeout_o`=1, `finished_o`, `ops_done_o`=0.
- `reset` asserted 5 cycles into a 100-op run → next cycle `busy_o`=0, `start`=0, LFSR=SEED; a rerun reproduces an identical A/B/op sequence.
- 1000-op run, reference model of LFSR mapping → every A/B/op matches; `start` never high on consecutive ops without a low cycle.
- Macro defined, 1000 ops → A==00 and A==FF each 20–30%. Macro undefined → each <2%.
